isdu_param: RTL and testbench

- Parametrised LC-3 instruction sequencer / control unit: the next generation of the lab 6 control FSM.
- Sits between the datapath (IR, BEN, register file, buses) and the external asynchronous SRAM.
- Adds configurable memory latency (cycle counter or ready handshake) and an optional fetch pause.
- Implements the complete subset ADD/AND/NOT/BR/JMP/JSR/JSRR/LDR/STR/PAUSE, and drives every datapath mux, gate and load strobe.

---
 rtl/isdu_pkg.sv | 34 +++
 rtl/isdu_mem_timer.sv | 32 +++
 rtl/isdu_param.sv | 148 ++++++++++++++
 tb/tb_isdu_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/isdu_pkg.sv
// Shared types and encodings for the parametrised LC-3 sequencer.
package isdu_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_18, S_33, S_35, S_PAUSE1, S_PAUSE2, S_32,
    S_01, S_05, S_09, S_06, S_07, S_25, S_27, S_23, S_16,
    S_00, S_22, S_12, S_04, S_21
  } state_e;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

endpackage

// File: rtl/isdu_mem_timer.sv
// SRAM access timer: counts cycles of an access and flags its final cycle.
module isdu_mem_timer #(
  parameter int MEM_WAIT      = 2,
  parameter int MEM_HANDSHAKE = 0,
  parameter int CNT_W         = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic mem_ready_i,
  output logic done_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign done_o  = active_i && at_last && ((MEM_HANDSHAKE == 0) || mem_ready_i);

  // Hold at LAST while a handshake access waits for the SRAM.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || done_o) cnt_d = '0;
    else if (!at_last)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

endmodule

// File: rtl/isdu_param.sv
// LC-3 control FSM: decodes every datapath strobe and SRAM strobe from state.
module isdu_param
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT      = 2,
  parameter int MEM_HANDSHAKE = 0,
  parameter int FETCH_PAUSE   = 0,
  parameter int CNT_W         = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Ready,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE, Mem_UB, Mem_LB,
  output logic       Mem_OE, Mem_WE
);
  state_e state_q, state_d;
  logic   pause_fetch_q, pause_fetch_d;
  logic   mem_active, mem_done;

  assign mem_active = state_q inside {S_33, S_25, S_16};

  isdu_mem_timer #(
    .MEM_WAIT(MEM_WAIT), .MEM_HANDSHAKE(MEM_HANDSHAKE), .CNT_W(CNT_W)
  ) u_timer (
    .clk_i(Clk), .rst_ni(Reset_n), .active_i(mem_active),
    .mem_ready_i(Mem_Ready), .done_o(mem_done)
  );

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  always_comb begin
    state_d = state_q;  pause_fetch_d = pause_fetch_q;
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC  = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_INC; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = A2_ZERO; ALUK = ALU_ADD;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_q)
      S_HALTED: if (Run) state_d = S_18;
      S_18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_INC; LD_PC = 1'b1;
        state_d = S_33;
      end
      S_33, S_25: begin
        Mem_OE = 1'b0;
        if (mem_done) begin
          LD_MDR  = 1'b1;
          state_d = (state_q == S_33) ? S_35 : S_27;
        end
      end
      S_35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        if (FETCH_PAUSE != 0) begin
          pause_fetch_d = 1'b1; state_d = S_PAUSE1;
        end else state_d = S_32;
      end
      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = S_PAUSE2;
      end
      // A fetch pause resumes decode; a PAUSE instruction resumes fetching.
      S_PAUSE2: if (!Continue) state_d = pause_fetch_q ? S_32 : S_18;
      S_32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:   state_d = S_01;
          OP_AND:   state_d = S_05;
          OP_NOT:   state_d = S_09;
          OP_BR:    state_d = S_00;
          OP_JMP:   state_d = S_12;
          OP_JSR:   state_d = S_04;
          OP_LDR:   state_d = S_06;
          OP_STR:   state_d = S_07;
          OP_PAUSE: begin pause_fetch_d = 1'b0; state_d = S_PAUSE1; end
          default:  state_d = S_18;
        endcase
      end
      S_01, S_05: begin
        SR1MUX = 1'b1; SR2MUX = IR_5; ALUK = (state_q == S_01) ? ALU_ADD : ALU_AND;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; state_d = S_18;
      end
      S_09: begin
        SR1MUX = 1'b1; ALUK = ALU_NOT;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; state_d = S_18;
      end
      S_06, S_07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF6;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
        state_d = (state_q == S_06) ? S_25 : S_23;
      end
      S_27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; state_d = S_18;
      end
      S_23: begin
        SR1MUX = 1'b0; ALUK = ALU_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
        state_d = S_16;
      end
      S_16: begin
        Mem_WE = 1'b0;
        if (mem_done) state_d = S_18;
      end
      S_00: state_d = BEN ? S_22 : S_18;
      S_22: begin
        ADDR2MUX = A2_OFF9; PCMUX = PCMUX_ADDR; LD_PC = 1'b1; state_d = S_18;
      end
      S_12: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
        state_d = S_18;
      end
      S_04: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; state_d = S_21;
      end
      S_21: begin
        if (IR_11) ADDR2MUX = A2_OFF11;
        else begin
          SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_ZERO;
        end
        PCMUX = PCMUX_ADDR; LD_PC = 1'b1; state_d = S_18;
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q       <= S_HALTED;
      pause_fetch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pause_fetch_q <= pause_fetch_d;
    end

endmodule

// File: tb/tb_isdu_param.sv
// Scoreboard bench: two sequencer configurations share stimulus, one is checked at a time.
module tb_isdu_param;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n, Run, Continue, IR_5, IR_11, BEN, Mem_Ready;
  logic [3:0] Opcode;

  logic a_ldmar, a_ldmdr, a_ldir, a_ldben, a_ldcc, a_ldreg, a_ldpc, a_ldled;
  logic a_gpc, a_gmdr, a_galu, a_gmarmux, a_dr, a_sr1, a_sr2, a_a1;
  logic a_ce, a_ub, a_lb, a_oe, a_we;
  logic [1:0] a_pcmux, a_a2, a_aluk;
  logic b_ldmar, b_ldmdr, b_ldir, b_ldben, b_ldcc, b_ldreg, b_ldpc, b_ldled;
  logic b_gpc, b_gmdr, b_galu, b_gmarmux, b_dr, b_sr1, b_sr2, b_a1;
  logic b_ce, b_ub, b_lb, b_oe, b_we;
  logic [1:0] b_pcmux, b_a2, b_aluk;

  isdu_param #(.MEM_WAIT(2), .MEM_HANDSHAKE(0), .FETCH_PAUSE(0), .CNT_W(4)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_Ready(Mem_Ready),
    .LD_MAR(a_ldmar), .LD_MDR(a_ldmdr), .LD_IR(a_ldir), .LD_BEN(a_ldben),
    .LD_CC(a_ldcc), .LD_REG(a_ldreg), .LD_PC(a_ldpc), .LD_LED(a_ldled),
    .GatePC(a_gpc), .GateMDR(a_gmdr), .GateALU(a_galu), .GateMARMUX(a_gmarmux),
    .PCMUX(a_pcmux), .DRMUX(a_dr), .SR1MUX(a_sr1), .SR2MUX(a_sr2),
    .ADDR1MUX(a_a1), .ADDR2MUX(a_a2), .ALUK(a_aluk),
    .Mem_CE(a_ce), .Mem_UB(a_ub), .Mem_LB(a_lb), .Mem_OE(a_oe), .Mem_WE(a_we));

  isdu_param #(.MEM_WAIT(3), .MEM_HANDSHAKE(1), .FETCH_PAUSE(1), .CNT_W(4)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_Ready(Mem_Ready),
    .LD_MAR(b_ldmar), .LD_MDR(b_ldmdr), .LD_IR(b_ldir), .LD_BEN(b_ldben),
    .LD_CC(b_ldcc), .LD_REG(b_ldreg), .LD_PC(b_ldpc), .LD_LED(b_ldled),
    .GatePC(b_gpc), .GateMDR(b_gmdr), .GateALU(b_galu), .GateMARMUX(b_gmarmux),
    .PCMUX(b_pcmux), .DRMUX(b_dr), .SR1MUX(b_sr1), .SR2MUX(b_sr2),
    .ADDR1MUX(b_a1), .ADDR2MUX(b_a2), .ALUK(b_aluk),
    .Mem_CE(b_ce), .Mem_UB(b_ub), .Mem_LB(b_lb), .Mem_OE(b_oe), .Mem_WE(b_we));

  // Bit layout: [7:0] loads, [11:8] gates, then mux selects, ALUK, OE, WE, CE, UB, LB.
  logic [26:0] ov_a, ov_b;
  assign ov_a = {a_lb, a_ub, a_ce, a_we, a_oe, a_aluk, a_a2, a_a1, a_sr2, a_sr1, a_dr, a_pcmux,
                 a_gmarmux, a_galu, a_gmdr, a_gpc,
                 a_ldled, a_ldpc, a_ldreg, a_ldcc, a_ldben, a_ldir, a_ldmdr, a_ldmar};
  assign ov_b = {b_lb, b_ub, b_ce, b_we, b_oe, b_aluk, b_a2, b_a1, b_sr2, b_sr1, b_dr, b_pcmux,
                 b_gmarmux, b_galu, b_gmdr, b_gpc,
                 b_ldled, b_ldpc, b_ldreg, b_ldcc, b_ldben, b_ldir, b_ldmdr, b_ldmar};

  localparam logic [26:0] LDMAR = 27'h1, LDMDR = 27'h2, LDIR = 27'h4, LDBEN = 27'h8;
  localparam logic [26:0] LDCC = 27'h10, LDREG = 27'h20, LDPC = 27'h40, LDLED = 27'h80;
  localparam logic [26:0] GPC = 27'h100, GMDR = 27'h200, GALU = 27'h400, GMARMUX = 27'h800;
  localparam logic [26:0] PC_ADDR = 27'h2000, DRM = 27'h4000, SR1 = 27'h8000;
  localparam logic [26:0] SR2 = 27'h10000, A1 = 27'h20000;
  localparam logic [26:0] A2_OFF6 = 27'h40000, A2_OFF9 = 27'h80000, A2_OFF11 = 27'hC0000;
  localparam logic [26:0] ALU_AND = 27'h100000, ALU_NOT = 27'h200000, ALU_PASS = 27'h300000;
  localparam logic [26:0] OE = 27'h400000, WE = 27'h800000;
  localparam logic [26:0] DEF = OE | WE;

  typedef struct {
    bit          sel;
    logic [26:0] exp;
    string       tag;
  } ent_t;
  ent_t sb[$];

  int n_chk = 0, n_pass = 0;
  bit cur = 1'b0, hs = 1'b0;

  task automatic chk(input string tag, input logic [26:0] got, input logic [26:0] want);
    n_chk++;
    if (got !== want) $display("FAIL %s: got %h expected %h", tag, got, want);
    else n_pass++;
  endtask

  always @(negedge Clk) begin
    ent_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.sel ? ov_b : ov_a, e.exp);
    end
  end

  task automatic cyc(input string tag, input logic [26:0] e);
    sb.push_back('{sel: cur, exp: e, tag: tag});
    @(posedge Clk); #1;
  endtask

  // One SRAM access; Mem_Ready stays low for the first 'stall' cycles.
  task automatic memacc(input string tag, input int mw, input int stall, input bit wr);
    bit done;
    for (int i = 0; i < 64; i++) begin
      Mem_Ready = (i >= stall);
      done = (i >= mw - 1) && (!hs || Mem_Ready);
      cyc(tag, wr ? OE : (WE | (done ? LDMDR : 27'h0)));
      if (done) break;
    end
    Mem_Ready = 1'b1;
  endtask

  task automatic pause_seq(input string tag);
    Continue = 1'b0; cyc({tag, "_p1"}, DEF | LDLED);
    Continue = 1'b1; cyc({tag, "_p1c"}, DEF | LDLED);
    cyc({tag, "_p2c"}, DEF);
    Continue = 1'b0; cyc({tag, "_p2"}, DEF);
  endtask

  task automatic fetch(input int mw, input int stall, input bit fp);
    cyc("s18", DEF | GPC | LDMAR | LDPC);
    memacc("s33", mw, stall, 1'b0);
    cyc("s35", DEF | GMDR | LDIR);
    if (fp) pause_seq("fp");
    cyc("s32", DEF | LDBEN);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'h0;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; Mem_Ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_a", ov_a, DEF);
    chk("rst_b", ov_b, DEF);
    Reset_n = 1'b1;

    // Config A: MEM_WAIT=2, counter timing, no fetch pause; Run held high throughout.
    cur = 1'b0; hs = 1'b0;
    cyc("halt_idle", DEF);
    Run = 1'b1;
    cyc("halt_run", DEF);
    Opcode = 4'b0001; IR_5 = 1'b1; fetch(2, 0, 1'b0);
    cyc("add", DEF | SR1 | SR2 | GALU | LDREG | LDCC);
    Opcode = 4'b0101; IR_5 = 1'b0; fetch(2, 0, 1'b0);
    cyc("and", DEF | SR1 | ALU_AND | GALU | LDREG | LDCC);
    Opcode = 4'b1001; fetch(2, 0, 1'b0);
    cyc("not", DEF | SR1 | ALU_NOT | GALU | LDREG | LDCC);
    Opcode = 4'b0000; BEN = 1'b0; fetch(2, 0, 1'b0);
    cyc("br_nt", DEF);
    BEN = 1'b1; fetch(2, 0, 1'b0);
    cyc("br_t", DEF);
    cyc("s22", DEF | A2_OFF9 | PC_ADDR | LDPC);
    Opcode = 4'b1100; fetch(2, 0, 1'b0);
    cyc("jmp", DEF | SR1 | A1 | PC_ADDR | LDPC);
    Opcode = 4'b0100; IR_11 = 1'b0; fetch(2, 0, 1'b0);
    cyc("s04", DEF | GPC | DRM | LDREG);
    cyc("jsrr", DEF | SR1 | A1 | PC_ADDR | LDPC);
    IR_11 = 1'b1; fetch(2, 0, 1'b0);
    cyc("s04", DEF | GPC | DRM | LDREG);
    cyc("jsr", DEF | A2_OFF11 | PC_ADDR | LDPC);
    Opcode = 4'b0110; fetch(2, 0, 1'b0);
    cyc("s06", DEF | SR1 | A1 | A2_OFF6 | GMARMUX | LDMAR);
    memacc("s25", 2, 0, 1'b0);
    cyc("s27", DEF | GMDR | LDREG | LDCC);
    Opcode = 4'b1111; fetch(2, 0, 1'b0);
    Opcode = 4'b0111; fetch(2, 0, 1'b0);
    cyc("s07", DEF | SR1 | A1 | A2_OFF6 | GMARMUX | LDMAR);
    cyc("s23", DEF | ALU_PASS | GALU | LDMDR);
    memacc("s16", 2, 0, 1'b1);
    cyc("s18_end", DEF | GPC | LDMAR | LDPC);

    // Config B: MEM_WAIT=3, Mem_Ready handshake, fetch pause.
    Run = 1'b0; Reset_n = 1'b0;
    @(posedge Clk); #1;
    chk("rst_b2", ov_b, DEF);
    Reset_n = 1'b1;
    cur = 1'b1; hs = 1'b1;
    Run = 1'b1;
    cyc("halt_run", DEF);
    Run = 1'b0;
    Opcode = 4'b0111; fetch(3, 6, 1'b1);
    Continue = 1'b1;
    cyc("s07", DEF | SR1 | A1 | A2_OFF6 | GMARMUX | LDMAR);
    Continue = 1'b0;
    cyc("s23", DEF | ALU_PASS | GALU | LDMDR);
    memacc("s16", 3, 0, 1'b1);
    Opcode = 4'b1101; fetch(3, 0, 1'b1);
    pause_seq("op");
    Opcode = 4'b0111; fetch(3, 0, 1'b1);
    cyc("s07", DEF | SR1 | A1 | A2_OFF6 | GMARMUX | LDMAR);
    cyc("s23", DEF | ALU_PASS | GALU | LDMDR);
    #2;
    chk("s16_mid", ov_b, OE);
    Reset_n = 1'b0;
    #1;
    chk("rst_async", ov_b, DEF);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    cyc("halt_after", DEF);
    cyc("halt_after2", DEF);
    Run = 1'b1;
    cyc("halt_rerun", DEF);
    Run = 1'b0;
    cyc("s18_restart", DEF | GPC | LDMAR | LDPC);

    @(negedge Clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
